memory_dump_reader: RTL and testbench
=====================================

# memory_dump_reader

Debug-side reader for the data memory's combinational debug port. On a start request it walks every word of the data memory (address 0 to 4·(TAM-1), step 4) and serializes each 32-bit word as four bytes, LSB first, over a valid/ready byte stream toward the debug UART transmitter. It sits between the debug unit's command decoder and the UART TX, driving the memory's debug address input and consuming its debug data output.

## Interface
- NB, 32, data word width (must equal memory word width)
- TAM, 16, number of memory words to dump (≥2)
- NB_BYTE, 8, width of serialized byte
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  dump request; sampled only in IDLE
- i_debug_data  in  NB  word read combinationally from memory at o_debug_address
- i_tx_ready  in  1  TX can accept a byte this cycle
- o_debug_address  out  NB  byte address presented to memory debug port
- o_tx_data  out  NB_BYTE  byte to transmit
- o_tx_valid  out  1  o_tx_data valid
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after last byte accepted

## Operation
- States: IDLE, LOAD, SEND, DONE.
- IDLE: o_busy=0; i_start=1 at edge → LOAD, word index=0.
- LOAD: capture i_debug_data into word register, byte count=0 → SEND.
- SEND: o_tx_valid=1, o_tx_data = word[8·cnt+7 : 8·cnt]. Transfer occurs on edge with o_tx_valid & i_tx_ready.
  - transfer, cnt<3 → cnt+1, stay SEND.
  - transfer, cnt=3, index<TAM-1 → index+1, LOAD.
  - transfer, cnt=3, index=TAM-1 → DONE.
  - no transfer → hold o_tx_data, o_tx_valid, cnt unchanged (data must not change while valid and not accepted).
- DONE: o_done=1 for exactly one cycle → IDLE.
- o_debug_address = {index, 2'b00}, zero-extended to NB; driven in all states (0 in IDLE after completion).
- Index width $clog2(TAM); byte count 2 bits; no wrap beyond TAM-1.
- i_start ignored outside IDLE; i_start high in DONE cycle does not restart.
- Memory writes during a dump are not blocked; the word captured in LOAD is what gets sent.

## Timing
- Reset (i_reset=0, async): state IDLE, index=0, cnt=0, word=0; o_debug_address=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0. Reset mid-dump aborts immediately; no partial-byte completion.
- Start at edge k → LOAD in cycle k+1 → first byte valid in cycle k+2.
- With i_tx_ready held 1: 5 cycles per word; o_done high in cycle k+1+5·TAM; back in IDLE next cycle.
- Each i_tx_ready=0 cycle during SEND adds one cycle.
- o_tx_valid never asserted in IDLE, LOAD, DONE.
- Outputs o_tx_data, o_tx_valid, o_busy, o_done registered or decoded from registered state only; no combinational path from i_tx_ready to o_tx_valid.

## Structure
- Shared debug package: state encoding (2-bit localparams IDLE/LOAD/SEND/DONE), NB_BYTE, BYTES_PER_WORD=4.
- Single module; byte selection is an inline mux, no sub-module.

## Test plan
- Reset values: hold i_reset=0 → all outputs 0; release, no i_start → stays IDLE, o_busy=0.
- Full dump, i_tx_ready=1, memory[i]=i, TAM=16: byte stream 00 00 00 00, 01 00 00 00 … 0F 00 00 00 (64 bytes), o_done at cycle k+81, o_debug_address sequence 0,4,…,60.
- Backpressure: memory[1]=32'hA1B2C3D4, i_tx_ready toggling 1/0 → bytes D4 C3 B2 A1 for word 1, o_tx_data stable while ready=0, no byte lost or duplicated.
- i_start pulses during SEND and in DONE cycle → ignored; exactly one 64-byte dump, one o_done pulse.
- Async reset asserted mid-word (after 2 bytes of word 3) → outputs 0 immediately; new i_start restarts from address 0 with byte 00.
- Memory written at word 7 while dumping word 2 → new value appears in word 7's bytes.

Source files
------------

// File: rtl/memory_dump_reader_pkg.sv
// Shared debug constants for the memory dump reader.
// State encoding and byte-stream geometry.
package memory_dump_reader_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int DBG_NB_BYTE    = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/memory_dump_reader.sv
// Walks the data memory debug port and streams every word
// out as four bytes, LSB first, on a valid/ready interface.
module memory_dump_reader
  import memory_dump_reader_pkg::*;
#(
  parameter int NB      = 32,
  parameter int TAM     = 16,
  parameter int NB_BYTE = DBG_NB_BYTE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB-1:0]      i_debug_data,
  input  logic               i_tx_ready,
  output logic [NB-1:0]      o_debug_address,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int IW = $clog2(TAM);
  localparam logic [IW-1:0] LAST_IDX = IW'(TAM - 1);
  localparam logic [1:0] LAST_CNT = 2'(BYTES_PER_WORD - 1);

  logic [1:0]         state;
  logic [IW-1:0]      index;
  logic [1:0]         cnt;
  logic [NB-1:0]      word;
  logic [NB_BYTE-1:0] byte_sel;
  logic               transfer;

  assign transfer = (state == S_SEND) && i_tx_ready;

  // Walk words, capture each one, then hand out its bytes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
      index <= '0;
      cnt   <= '0;
      word  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_LOAD;
            index <= '0;
          end
        end
        S_LOAD: begin
          word  <= i_debug_data;
          cnt   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (transfer) begin
            if (cnt != LAST_CNT) begin
              cnt <= cnt + 2'd1;
            end else if (index != LAST_IDX) begin
              index <= index + IW'(1);
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          index <= '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; the byte mux
  // is held stable while a byte waits for acceptance.
  always_comb begin
    byte_sel        = word[cnt*NB_BYTE +: NB_BYTE];
    o_tx_valid      = (state == S_SEND);
    o_busy          = (state != S_IDLE);
    o_done          = (state == S_DONE);
    o_tx_data       = o_tx_valid ? byte_sel : '0;
    o_debug_address = NB'({index, 2'b00});
  end

endmodule

// File: tb/tb_memory_dump_reader.sv
// Bench for memory_dump_reader: table-driven dumps against a
// byte-stream model, plus reset and abort sequences.
module tb_memory_dump_reader;

  localparam int NB  = 32;
  localparam int TAM = 16;
  localparam int NBB = 8;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b0;
  logic            i_start = 1'b0;
  logic            i_tx_ready = 1'b0;
  logic [NB-1:0]   i_debug_data;
  logic [NB-1:0]   o_debug_address;
  logic [NBB-1:0]  o_tx_data;
  logic            o_tx_valid;
  logic            o_busy;
  logic            o_done;

  logic [31:0] mem [TAM];

  assign i_debug_data = mem[o_debug_address[5:2]];

  always #5 i_clk = ~i_clk;

  memory_dump_reader #(.NB(NB), .TAM(TAM), .NB_BYTE(NBB)) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_start         (i_start),
    .i_debug_data    (i_debug_data),
    .i_tx_ready      (i_tx_ready),
    .o_debug_address (o_debug_address),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          ready_mode = 0;
  logic [7:0]  got [$];
  logic [31:0] addrs [$];
  int          stalls = 0;
  int          dones = 0;
  logic        hold_p = 1'b0;
  logic [7:0]  hold_d = '0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives ready and observes the stream at the falling edge.
  initial begin
    forever begin
      @(negedge i_clk);
      case (ready_mode)
        0: i_tx_ready = 1'b1;
        1: i_tx_ready = ~i_tx_ready;
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold_p) begin
        check("hold_valid", 64'(o_tx_valid), 64'd1);
        check("hold_data", 64'(o_tx_data), 64'(hold_d));
      end
      hold_p = o_tx_valid && !i_tx_ready;
      hold_d = o_tx_data;
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (o_tx_valid && !i_tx_ready) stalls++;
      if (o_busy && !o_tx_valid && !o_done) addrs.push_back(o_debug_address);
      if (o_done) dones++;
    end
  end

  task automatic fill_mem(input int kind);
    for (int i = 0; i < TAM; i++) begin
      mem[i] = (kind == 0) ? 32'(i) : $urandom;
    end
    if (kind == 1) mem[1] = 32'hA1B2C3D4;
  endtask

  task automatic run_dump(input bit pulses, input bit wr7,
                          output int cyc);
    int n;
    bit written;
    written = 1'b0;
    got.delete();
    addrs.delete();
    stalls = 0;
    dones = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 1;
    while (!o_done && n < 3000) begin
      i_start = (pulses && (n % 37 == 5)) ? 1'b1 : 1'b0;
      if (wr7 && !written && o_debug_address == 32'd8) begin
        mem[7] = $urandom;
        written = 1'b1;
      end
      @(negedge i_clk);
      n++;
    end
    i_start = 1'b0;
    cyc = n;
    if (!o_done) check("done_timeout", 64'(o_done), 64'd1);
    if (pulses) i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("done_one_cycle", 64'(o_done), 64'd0);
    check("idle_after", 64'(o_busy), 64'd0);
    check("addr_after", 64'(o_debug_address), 64'd0);
    repeat (3) @(negedge i_clk);
    check("no_restart", 64'(o_busy), 64'd0);
  endtask

  task automatic check_stream(input int exp_bytes, input int exp_dones,
                              input int cyc);
    int bad;
    logic [31:0] w;
    logic [7:0] b;
    check("byte_count", 64'(got.size()), 64'(exp_bytes));
    bad = 0;
    for (int i = 0; i < TAM * 4; i++) begin
      w = mem[i / 4];
      b = w[8*(i%4) +: 8];
      if (i < got.size() && got[i] !== b) begin
        if (bad == 0) $display("FAIL stream_byte %0d: got %0h expected %0h",
                               i, got[i], b);
        bad++;
      end
    end
    check("stream", 64'(bad), 64'd0);
    check("addr_count", 64'(addrs.size()), 64'(TAM));
    bad = 0;
    for (int i = 0; i < TAM; i++) begin
      if (i < addrs.size() && addrs[i] !== 32'(4 * i)) bad++;
    end
    check("addr_seq", 64'(bad), 64'd0);
    check("done_pulses", 64'(dones), 64'(exp_dones));
    check("done_cycle", 64'(cyc), 64'(1 + 5 * TAM + stalls));
  endtask

  typedef struct {
    int fill;
    int rmode;
    bit pulses;
    bit wr7;
    int exp_bytes;
    int exp_dones;
  } vec_t;

  vec_t vt [4];

  initial begin
    int cyc;

    vt[0] = '{0, 0, 1'b0, 1'b0, 64, 1};
    vt[1] = '{1, 1, 1'b0, 1'b0, 64, 1};
    vt[2] = '{2, 2, 1'b1, 1'b0, 64, 1};
    vt[3] = '{2, 0, 1'b1, 1'b1, 64, 1};

    fill_mem(0);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_addr", 64'(o_debug_address), 64'd0);
    check("rst_data", 64'(o_tx_data), 64'd0);
    check("rst_valid", 64'(o_tx_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    i_reset = 1'b1;
    repeat (4) @(negedge i_clk);
    check("idle_busy", 64'(o_busy), 64'd0);
    check("idle_valid", 64'(o_tx_valid), 64'd0);

    for (int v = 0; v < 4; v++) begin
      fill_mem(vt[v].fill);
      ready_mode = vt[v].rmode;
      run_dump(vt[v].pulses, vt[v].wr7, cyc);
      check_stream(vt[v].exp_bytes, vt[v].exp_dones, cyc);
      if (vt[v].fill == 1 && got.size() >= 8)
        check("word1_bytes", 64'({got[7], got[6], got[5], got[4]}),
              64'h00000000A1B2C3D4);
      if (v == 0) check("done_cycle_81", 64'(cyc), 64'd81);
    end

    ready_mode = 0;
    fill_mem(0);
    got.delete();
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (18) @(posedge i_clk);
    #1;
    check("abort_addr", 64'(o_debug_address), 64'd12);
    check("abort_valid", 64'(o_tx_valid), 64'd1);
    check("abort_bytes_sent", 64'(got.size()), 64'd14);
    i_reset = 1'b0;
    #1;
    check("abort_addr0", 64'(o_debug_address), 64'd0);
    check("abort_valid0", 64'(o_tx_valid), 64'd0);
    check("abort_data0", 64'(o_tx_data), 64'd0);
    check("abort_busy0", 64'(o_busy), 64'd0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    fill_mem(2);
    run_dump(1'b0, 1'b0, cyc);
    check_stream(64, 1, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
